// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: owns the ID/EX slice for branch info, evaluates the
// B-type condition on forwarded operands, and keeps saturating branch statistics.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Stall_i,
  input  logic             Flush_ID_EX_i,
  input  logic             ID_Branch_i,
  input  logic             ID_predTaken_i,
  input  logic [2:0]       ID_funct3_i,
  input  logic [XLEN-1:0]  ID_pc_i,
  input  logic [XLEN-1:0]  ID_imm_i,
  input  logic [XLEN-1:0]  EX_rs1_data_i,
  input  logic [XLEN-1:0]  EX_rs2_data_i,
  input  logic             cnt_clr_i,
  output logic             EX_Branch_o,
  output logic             EX_predTaken_o,
  output logic             EX_realTaken_o,
  output logic             EX_mispredict_o,
  output logic [XLEN-1:0]  EX_redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // ID/EX slice
  // ---------------------------------------------------------------------------
  logic            branch_q, branch_d;
  logic            pred_q,   pred_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] imm_q,    imm_d;

  logic bubble;
  assign bubble = Flush_ID_EX_i | Stall_i;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    branch_d = ID_Branch_i;
    pred_d   = ID_predTaken_i;
    funct3_d = ID_funct3_i;
    pc_d     = ID_pc_i;
    imm_d    = ID_imm_i;
    // A bubble only has to kill the control bits; data fields simply hold.
    if (bubble) begin
      branch_d = 1'b0;
      pred_d   = 1'b0;
      funct3_d = funct3_q;
      pc_d     = pc_q;
      imm_d    = imm_q;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i) begin
      branch_q <= 1'b0;
      pred_q   <= 1'b0;
      funct3_q <= 3'b000;
      pc_q     <= '0;
      imm_q    <= '0;
    end else begin
      branch_q <= branch_d;
      pred_q   <= pred_d;
      funct3_q <= funct3_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation and redirect target
  // ---------------------------------------------------------------------------
  logic rs_eq, rs_lt_s, rs_lt_u;
  logic cond;

  assign rs_eq   = (EX_rs1_data_i == EX_rs2_data_i);
  assign rs_lt_s = ($signed(EX_rs1_data_i) < $signed(EX_rs2_data_i));
  assign rs_lt_u = (EX_rs1_data_i < EX_rs2_data_i);

  always_comb begin
    cond = 1'b0;
    case (funct3_q)
      F3_BEQ:  cond = rs_eq;
      F3_BNE:  cond = ~rs_eq;
      F3_BLT:  cond = rs_lt_s;
      F3_BGE:  cond = ~rs_lt_s;
      F3_BLTU: cond = rs_lt_u;
      F3_BGEU: cond = ~rs_lt_u;
      default: cond = 1'b0;  // 010/011 are not branches: never taken
    endcase
  end

  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] fallthrough_pc;

  assign target_pc      = pc_q + imm_q;
  assign fallthrough_pc = pc_q + PC_STEP;

  assign EX_Branch_o      = branch_q;
  assign EX_predTaken_o   = branch_q & pred_q;
  assign EX_realTaken_o   = branch_q & cond;
  assign EX_mispredict_o  = branch_q & (EX_realTaken_o ^ EX_predTaken_o);
  assign EX_redirect_pc_o = EX_realTaken_o ? target_pc : fallthrough_pc;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q,   taken_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    // Clear beats any same-cycle increment.
    if (cnt_clr_i) begin
      branch_cnt_d  = '0;
      taken_cnt_d   = '0;
      mispred_cnt_d = '0;
    end else if (EX_Branch_o) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (EX_realTaken_o)  taken_cnt_d   = sat_inc(taken_cnt_q);
      if (EX_mispredict_o) mispred_cnt_d = sat_inc(mispred_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign taken_cnt_o   = taken_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule
